// File: rtl/sched_phase_if.sv
// Handshake and datapath bundle between a run requester and sched_phase_ctrl.
// The abort/aborted pair exists only when SCHED_ABORT_EN is defined.
interface sched_phase_if #(
    parameter int SEED_W  = 8,
    parameter int STATE_W = 3,
    parameter int LEN_W   = 16,
    parameter int BR_W    = 8
);
    logic               start;
    logic [SEED_W-1:0]  seed_ID;
    logic [LEN_W-1:0]   seq_len;
    logic [BR_W-1:0]    num_branches;
    logic               stall;
    logic [STATE_W-1:0] state;
    logic               seed_load;
    logic [SEED_W-1:0]  seed_out;
    logic               site_valid;
    logic [LEN_W-1:0]   site_idx;
    logic [BR_W-1:0]    branch_idx;
    logic               busy;
    logic               done;
`ifdef SCHED_ABORT_EN
    logic               abort;
    logic               aborted;
`endif

    modport master (
`ifdef SCHED_ABORT_EN
        output abort,
        input  aborted,
`endif
        output start, seed_ID, seq_len, num_branches, stall,
        input  state, seed_load, seed_out, site_valid, site_idx, branch_idx, busy, done
    );

    modport slave (
`ifdef SCHED_ABORT_EN
        input  abort,
        output aborted,
`endif
        input  start, seed_ID, seq_len, num_branches, stall,
        output state, seed_load, seed_out, site_valid, site_idx, branch_idx, busy, done
    );
endinterface

// File: rtl/sched_phase_ctrl.sv
// Multi-phase run controller: seed load, RNG warm-up, root generation, branch evolution, flush.
// Optional abort input/aborted output enabled by defining SCHED_ABORT_EN.
module sched_phase_ctrl #(
    parameter int SEED_W     = 8,
    parameter int STATE_W    = 3,
    parameter int LEN_W      = 16,
    parameter int BR_W       = 8,
    parameter int WARMUP_CYC = 16,
    parameter int FLUSH_CYC  = 4
) (
    input logic          clk,
    input logic          reset,
    sched_phase_if.slave bus
);
    localparam int CNT_MAX = (WARMUP_CYC > FLUSH_CYC) ? WARMUP_CYC : FLUSH_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYC - 1);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = STATE_W'(0),
        S_LOAD   = STATE_W'(1),
        S_WARMUP = STATE_W'(2),
        S_ROOT   = STATE_W'(3),
        S_EVOLVE = STATE_W'(4),
        S_FLUSH  = STATE_W'(5),
        S_DONE   = STATE_W'(6)
    } phase_e;

    phase_e            state_q, state_d;
    logic [LEN_W-1:0]  site_q, site_d, len_q, len_d;
    logic [BR_W-1:0]   branch_q, branch_d, nbr_q, nbr_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              site_valid_q, site_valid_d;
    logic              seed_load_q, seed_load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_site, last_branch;
`ifdef SCHED_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    assign last_site   = (site_q == len_q - LEN_W'(1));
    assign last_branch = (branch_q == nbr_q - BR_W'(1));

    // site_valid_q marks the site shown this cycle as issued, so the pointer only advances past it.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d  = state_q;
        site_d   = site_q;
        branch_d = branch_q;
        cnt_d    = cnt_q;
        seed_d   = seed_q;
        len_d    = len_q;
        nbr_d    = nbr_q;

        case (state_q)
            S_LOAD: begin
                state_d = S_WARMUP;
                cnt_d   = '0;
            end
            S_WARMUP: begin
                if (cnt_q == WARMUP_LAST) begin
                    state_d  = S_ROOT;
                    site_d   = '0;
                    branch_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ROOT: begin
                if (site_valid_q) begin
                    if (last_site) begin
                        site_d  = '0;
                        cnt_d   = '0;
                        state_d = (nbr_q == '0) ? S_FLUSH : S_EVOLVE;
                    end else begin
                        site_d = site_q + LEN_W'(1);
                    end
                end
            end
            S_EVOLVE: begin
                if (site_valid_q) begin
                    if (last_site) begin
                        site_d = '0;
                        if (last_branch) begin
                            branch_d = '0;
                            cnt_d    = '0;
                            state_d  = S_FLUSH;
                        end else begin
                            branch_d = branch_q + BR_W'(1);
                        end
                    end else begin
                        site_d = site_q + LEN_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) state_d = S_DONE;
                else                     cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                // IDLE, and the unused encoding which behaves as IDLE.
                state_d = S_IDLE;
                if (bus.start) begin
                    seed_d   = bus.seed_ID;
                    len_d    = bus.seq_len;
                    nbr_d    = bus.num_branches;
                    site_d   = '0;
                    branch_d = '0;
                    state_d  = (bus.seq_len == '0) ? S_DONE : S_LOAD;
                end
            end
        endcase

`ifdef SCHED_ABORT_EN
        aborted_d = 1'b0;
        if (bus.abort && (state_q inside {S_LOAD, S_WARMUP, S_ROOT, S_EVOLVE, S_FLUSH, S_DONE})) begin
            state_d   = S_IDLE;
            site_d    = '0;
            branch_d  = '0;
            cnt_d     = '0;
            aborted_d = 1'b1;
        end
`endif

        // Outputs are registered copies of what the next state presents.
        site_valid_d = ((state_d == S_ROOT) || (state_d == S_EVOLVE)) && !bus.stall;
        seed_load_d  = (state_d == S_LOAD);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q      <= S_IDLE;
            site_q       <= '0;
            branch_q     <= '0;
            cnt_q        <= '0;
            seed_q       <= '0;
            len_q        <= '0;
            nbr_q        <= '0;
            site_valid_q <= 1'b0;
            seed_load_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SCHED_ABORT_EN
            aborted_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            site_q       <= site_d;
            branch_q     <= branch_d;
            cnt_q        <= cnt_d;
            seed_q       <= seed_d;
            len_q        <= len_d;
            nbr_q        <= nbr_d;
            site_valid_q <= site_valid_d;
            seed_load_q  <= seed_load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SCHED_ABORT_EN
            aborted_q    <= aborted_d;
`endif
        end
    end

    assign bus.state      = state_q;
    assign bus.seed_load  = seed_load_q;
    assign bus.seed_out   = seed_q;
    assign bus.site_valid = site_valid_q;
    assign bus.site_idx   = site_q;
    assign bus.branch_idx = branch_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef SCHED_ABORT_EN
    assign bus.aborted    = aborted_q;
`endif

endmodule
